// File: rtl/icache_fetch_arbiter.sv
// icache_fetch_arbiter: round-robin share of one I-cache fetch port between two IFU ways.
// Define ICARB_PERF_CNT_EN to add saturating delivery and conflict counters.
module icache_fetch_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int INST_W    = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              way0_request_i,
    input  logic [ADDR_W-1:0] way0_instAddr_i,
    input  logic              way0_flush_i,
    output logic              way0_dataOk_o,
    output logic [INST_W-1:0] way0_inst_o,
    input  logic              way1_request_i,
    input  logic [ADDR_W-1:0] way1_instAddr_i,
    input  logic              way1_flush_i,
    output logic              way1_dataOk_o,
    output logic [INST_W-1:0] way1_inst_o,
    output logic              ic_request_o,
    output logic [ADDR_W-1:0] ic_instAddr_o,
    input  logic              ic_dataOk_i,
    input  logic [INST_W-1:0] ic_inst_i,
    output logic              grant_o,
    output logic              busy_o
`ifdef ICARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_way0_cnt_o,
    output logic [31:0]       perf_way1_cnt_o,
    output logic [31:0]       perf_conflict_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state;
    logic   prio;
    logic   elig0, elig1, hold, pick, want, owner_flush;
    assign elig0       = way0_request_i && !way0_flush_i;
    assign elig1       = way1_request_i && !way1_flush_i;
    assign pick        = (elig0 && elig1) ? !prio : elig1;
    // the requester still holds request while its dataOk_o is visible, so no grant that cycle
    assign hold        = way0_dataOk_o || way1_dataOk_o;
    assign want        = (elig0 || elig1) && !hold;
    assign owner_flush = grant_o ? way1_flush_i : way0_flush_i;
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state         <= IDLE;
            prio          <= PRIO_INIT;
            grant_o       <= 1'b0;
            busy_o        <= 1'b0;
            ic_request_o  <= 1'b0;
            ic_instAddr_o <= '0;
            way0_dataOk_o <= 1'b0;
            way1_dataOk_o <= 1'b0;
            way0_inst_o   <= '0;
            way1_inst_o   <= '0;
        end else begin
            way0_dataOk_o <= 1'b0;
            way1_dataOk_o <= 1'b0;
            case (state)
                IDLE: if (want) begin
                    state         <= FETCH;
                    grant_o       <= pick;
                    prio          <= pick;
                    ic_instAddr_o <= pick ? way1_instAddr_i : way0_instAddr_i;
                    ic_request_o  <= 1'b1;
                    busy_o        <= 1'b1;
                end
                FETCH: if (ic_dataOk_i) begin
                    state        <= IDLE;
                    ic_request_o <= 1'b0;
                    busy_o       <= 1'b0;
                    if (!owner_flush && !grant_o) begin
                        way0_dataOk_o <= 1'b1;
                        way0_inst_o   <= ic_inst_i;
                    end
                    if (!owner_flush && grant_o) begin
                        way1_dataOk_o <= 1'b1;
                        way1_inst_o   <= ic_inst_i;
                    end
                end else if (owner_flush) begin
                    state <= DRAIN;
                end
                // the I-cache transaction is never aborted; wait out its response
                DRAIN: if (ic_dataOk_i) begin
                    state        <= IDLE;
                    ic_request_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ICARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset_n) begin
            perf_way0_cnt_o     <= '0;
            perf_way1_cnt_o     <= '0;
            perf_conflict_cnt_o <= '0;
        end else begin
            if (way0_dataOk_o && perf_way0_cnt_o != '1) perf_way0_cnt_o <= perf_way0_cnt_o + 32'd1;
            if (way1_dataOk_o && perf_way1_cnt_o != '1) perf_way1_cnt_o <= perf_way1_cnt_o + 32'd1;
            if (state == IDLE && elig0 && elig1 && perf_conflict_cnt_o != '1)
                perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// tb_icache_fetch_arbiter: scripted vector table plus randomized run against a transaction model.
module tb_icache_fetch_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        way0_request_i = 1'b0, way0_flush_i = 1'b0, way1_request_i = 1'b0, way1_flush_i = 1'b0;
    logic [31:0] way0_instAddr_i = 32'h8000_0000, way1_instAddr_i = 32'h9000_0004;
    logic        way0_dataOk_o, way1_dataOk_o, ic_request_o, ic_dataOk_i = 1'b0, grant_o, busy_o;
    logic [31:0] way0_inst_o, way1_inst_o, ic_instAddr_o, ic_inst_i = '0;
`ifdef ICARB_PERF_CNT_EN
    logic [31:0] perf_way0_cnt_o, perf_way1_cnt_o, perf_conflict_cnt_o;
    int unsigned m_pc0, m_pc1, m_pcc;
`endif
    int n_vec = 0, n_err = 0, lat = 1;

    icache_fetch_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .way0_request_i(way0_request_i), .way0_instAddr_i(way0_instAddr_i), .way0_flush_i(way0_flush_i),
        .way0_dataOk_o(way0_dataOk_o), .way0_inst_o(way0_inst_o),
        .way1_request_i(way1_request_i), .way1_instAddr_i(way1_instAddr_i), .way1_flush_i(way1_flush_i),
        .way1_dataOk_o(way1_dataOk_o), .way1_inst_o(way1_inst_o),
        .ic_request_o(ic_request_o), .ic_instAddr_o(ic_instAddr_o),
        .ic_dataOk_i(ic_dataOk_i), .ic_inst_i(ic_inst_i),
        .grant_o(grant_o), .busy_o(busy_o)
`ifdef ICARB_PERF_CNT_EN
        , .perf_way0_cnt_o(perf_way0_cnt_o), .perf_way1_cnt_o(perf_way1_cnt_o),
        .perf_conflict_cnt_o(perf_conflict_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, r0, f0, r1, f1, dok;
        logic [31:0] inst;
        bit          busy, grant, ok0, ok1;
        logic [31:0] i0, i1;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit r0, bit f0, bit r1, bit f1, bit dok, logic [31:0] inst,
                                bit busy, bit grant, bit ok0, bit ok1, logic [31:0] i0, logic [31:0] i1);
        vec_t v;
        v = '{rst, r0, f0, r1, f1, dok, inst, busy, grant, ok0, ok1, i0, i1};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // transaction-level reference: one outstanding fetch record with a killed flag
    bit          m_busy, m_owner, m_killed, m_last, m_ok0, m_ok1;
    logic [31:0] m_addr, m_inst0, m_inst1;

    task automatic model_next();
        bit e0, e1, was_ok, oflush;
        e0 = way0_request_i && !way0_flush_i;
        e1 = way1_request_i && !way1_flush_i;
        was_ok = m_ok0 || m_ok1;
`ifdef ICARB_PERF_CNT_EN
        if (!reset_n) begin
            if (m_ok0 && m_pc0 != 32'hFFFF_FFFF) m_pc0++;
            if (m_ok1 && m_pc1 != 32'hFFFF_FFFF) m_pc1++;
            if (!m_busy && e0 && e1 && m_pcc != 32'hFFFF_FFFF) m_pcc++;
        end else begin
            m_pc0 = 0; m_pc1 = 0; m_pcc = 0;
        end
`endif
        m_ok0 = 0;
        m_ok1 = 0;
        if (reset_n) begin
            m_busy = 0; m_owner = 0; m_killed = 0; m_last = 0; m_addr = 0; m_inst0 = 0; m_inst1 = 0;
        end else if (!m_busy) begin
            if (!was_ok && (e0 || e1)) begin
                m_owner  = (e0 && e1) ? !m_last : e1;
                m_last   = m_owner;
                m_busy   = 1;
                m_killed = 0;
                m_addr   = m_owner ? way1_instAddr_i : way0_instAddr_i;
            end
        end else begin
            oflush = m_owner ? way1_flush_i : way0_flush_i;
            if (ic_dataOk_i) begin
                m_busy = 0;
                if (!m_killed && !oflush) begin
                    if (m_owner) begin m_ok1 = 1; m_inst1 = ic_inst_i; end
                    else begin m_ok0 = 1; m_inst0 = ic_inst_i; end
                end
            end else if (oflush) m_killed = 1;
        end
    endtask

    task automatic drive_random();
        reset_n = ($urandom_range(0, 99) == 0);
        if (way0_dataOk_o) way0_request_i = 0;
        if (way1_dataOk_o) way1_request_i = 0;
        if (!way0_request_i && $urandom_range(0, 3) == 0) begin way0_request_i = 1; way0_instAddr_i = $urandom; end
        if (!way1_request_i && $urandom_range(0, 3) == 0) begin way1_request_i = 1; way1_instAddr_i = $urandom; end
        way0_flush_i = ($urandom_range(0, 11) == 0);
        way1_flush_i = ($urandom_range(0, 11) == 0);
        if (way0_flush_i && $urandom_range(0, 1) == 1) way0_request_i = 0;
        if (way1_flush_i && $urandom_range(0, 1) == 1) way1_request_i = 0;
        ic_dataOk_i = 0;
        if (ic_request_o) begin
            if (lat == 0) begin ic_dataOk_i = 1; ic_inst_i = $urandom; lat = $urandom_range(0, 3); end
            else lat--;
        end else if ($urandom_range(0, 15) == 0) begin
            ic_dataOk_i = 1; ic_inst_i = $urandom;
        end
    endtask

    initial begin
        tbl.push_back(mk(1,0,0,0,0,0,0,          0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,          1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,          1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,          1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,32'h13,     0,0,1,0,32'h13,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,32'h13,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,32'h13,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'hdead,   0,0,0,0,32'h13,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,          0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,0,0,          1,1,0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1,32'h11,     0,0,0,1,0,32'h11));
        tbl.push_back(mk(0,1,0,1,0,0,0,          0,0,0,0,0,32'h11));
        tbl.push_back(mk(0,1,0,1,0,0,0,          1,0,0,0,0,32'h11));
        tbl.push_back(mk(0,1,0,1,0,1,32'h22,     0,0,1,0,32'h22,32'h11));
        tbl.push_back(mk(0,1,0,1,0,0,0,          0,0,0,0,32'h22,32'h11));
        tbl.push_back(mk(0,1,0,1,0,0,0,          1,1,0,0,32'h22,32'h11));
        tbl.push_back(mk(0,1,0,1,0,1,32'h33,     0,0,0,1,32'h22,32'h33));
        tbl.push_back(mk(0,1,0,1,0,0,0,          0,0,0,0,32'h22,32'h33));
        tbl.push_back(mk(0,1,0,1,0,0,0,          1,0,0,0,32'h22,32'h33));
        tbl.push_back(mk(0,1,0,1,0,1,32'h44,     0,0,1,0,32'h44,32'h33));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,0,0,1,0,0,0,          1,1,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,0,0,1,1,0,0,          1,1,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,1,0,0,0,0,0,          1,1,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,1,0,0,0,0,0,          1,1,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,1,0,0,0,1,32'hbad,    0,0,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,1,0,0,0,0,0,          1,0,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,1,1,0,0,1,32'hbeef,   0,0,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,0,0,0,0,1,32'h55,     0,0,0,0,32'h44,32'h33));
        tbl.push_back(mk(0,1,0,0,0,0,0,          1,0,0,0,32'h44,32'h33));
        tbl.push_back(mk(1,1,0,0,0,0,0,          0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h66,     0,0,0,0,0,0));
        foreach (tbl[k]) begin
            reset_n = tbl[k].rst; way0_request_i = tbl[k].r0; way0_flush_i = tbl[k].f0;
            way1_request_i = tbl[k].r1; way1_flush_i = tbl[k].f1;
            ic_dataOk_i = tbl[k].dok; ic_inst_i = tbl[k].inst;
            @(posedge clk); #1;
            chk($sformatf("row%0d busy", k), busy_o, tbl[k].busy);
            chk($sformatf("row%0d ic_req", k), ic_request_o, tbl[k].busy);
            chk($sformatf("row%0d ok0", k), way0_dataOk_o, tbl[k].ok0);
            chk($sformatf("row%0d ok1", k), way1_dataOk_o, tbl[k].ok1);
            chk($sformatf("row%0d inst0", k), way0_inst_o, tbl[k].i0);
            chk($sformatf("row%0d inst1", k), way1_inst_o, tbl[k].i1);
            if (tbl[k].busy) begin
                chk($sformatf("row%0d grant", k), grant_o, tbl[k].grant);
                chk($sformatf("row%0d addr", k), ic_instAddr_o, tbl[k].grant ? 32'h9000_0004 : 32'h8000_0000);
            end
            if (tbl[k].rst) begin
                chk($sformatf("row%0d rst_grant", k), grant_o, 0);
                chk($sformatf("row%0d rst_addr", k), ic_instAddr_o, 0);
            end
        end
`ifdef ICARB_PERF_CNT_EN
        chk("perf_after_reset", perf_way0_cnt_o | perf_way1_cnt_o | perf_conflict_cnt_o, 0);
        m_pc0 = 0; m_pc1 = 0; m_pcc = 0;
`endif
        reset_n = 1; way0_request_i = 0; way1_request_i = 0; way0_flush_i = 0; way1_flush_i = 0;
        ic_dataOk_i = 0;
        for (int c = 0; c < 3000; c++) begin
            model_next();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d busy", c), busy_o, m_busy);
            chk($sformatf("rnd%0d ic_req", c), ic_request_o, m_busy);
            chk($sformatf("rnd%0d ok0", c), way0_dataOk_o, m_ok0);
            chk($sformatf("rnd%0d ok1", c), way1_dataOk_o, m_ok1);
            chk($sformatf("rnd%0d inst0", c), way0_inst_o, m_inst0);
            chk($sformatf("rnd%0d inst1", c), way1_inst_o, m_inst1);
            if (m_busy) begin
                chk($sformatf("rnd%0d grant", c), grant_o, m_owner);
                chk($sformatf("rnd%0d addr", c), ic_instAddr_o, m_addr);
            end
`ifdef ICARB_PERF_CNT_EN
            chk($sformatf("rnd%0d perf0", c), perf_way0_cnt_o, m_pc0);
            chk($sformatf("rnd%0d perf1", c), perf_way1_cnt_o, m_pc1);
            chk($sformatf("rnd%0d perfc", c), perf_conflict_cnt_o, m_pcc);
`endif
            drive_random();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
